// File: rtl/dram_request_arbiter.sv
// Round-robin arbiter sharing one DRAM controller read/writeback port among NUM_PORTS requesters.
// Optional watchdog on the controller ack, enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_request_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                     main_clk,
  input  logic                     main_reset,
  input  logic [NUM_PORTS-1:0]     port_req_pulse,
  input  logic [NUM_PORTS*13-1:0]  port_addr_read_upper,
  input  logic [NUM_PORTS*13-1:0]  port_addr_write_upper,
  input  logic [NUM_PORTS*9-1:0]   port_addr_common,
  input  logic [NUM_PORTS-1:0]     port_entry_dirty,
  input  logic [NUM_PORTS*128-1:0] port_lane_to_dram,
  output logic [NUM_PORTS-1:0]     port_ack_pulse,
  output logic [127:0]             port_lane_from_dram,
  output logic [12:0]              dram_addr_req_read,
  output logic [12:0]              dram_addr_req_write,
  output logic [8:0]               dram_addr_req_common,
  output logic [127:0]             dram_lane_to_dram,
  output logic                     dram_entry_dirty,
  output logic                     dram_req_read_pulse,
  input  logic [127:0]             dram_lane_from_dram,
  input  logic                     dram_ack_read_pulse,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t               state, state_next;
  logic [NUM_PORTS-1:0] pending, accept, clear_mask;
  logic [IW-1:0]        last_grant, owner, grant_idx, cand;
  logic                 grant_found, ack_take, timeout_hit;

  logic [12:0]  slot_read  [NUM_PORTS];
  logic [12:0]  slot_write [NUM_PORTS];
  logic [8:0]   slot_common[NUM_PORTS];
  logic         slot_dirty [NUM_PORTS];
  logic [127:0] slot_lane  [NUM_PORTS];

  assign accept   = port_req_pulse & ~pending;
  assign ack_take = (state == WAIT_ACK) && dram_ack_read_pulse;
  assign busy     = (state != IDLE) || (|pending);

  // NOTE: slot storage carries no reset; pending[] alone says whether a slot holds anything.
  always_ff @(posedge main_clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (accept[i]) begin
        slot_read[i]   <= port_addr_read_upper[i*13 +: 13];
        slot_write[i]  <= port_addr_write_upper[i*13 +: 13];
        slot_common[i] <= port_addr_common[i*9 +: 9];
        slot_dirty[i]  <= port_entry_dirty[i];
        slot_lane[i]   <= port_lane_to_dram[i*128 +: 128];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_PORTS);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    clear_mask        = '0;
    clear_mask[owner] = ack_take;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (grant_found) state_next = ISSUE;
      ISSUE:    state_next = WAIT_ACK;
      WAIT_ACK: if (ack_take || timeout_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

`ifdef DRAM_ARB_TIMEOUT_EN
  logic [11:0] wait_cnt;

  // Fires on the 4095th consecutive WAIT_ACK cycle without an ack; an ack in that cycle wins.
  assign timeout_hit = (state == WAIT_ACK) && !dram_ack_read_pulse && (wait_cnt == 12'd4094);

  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == WAIT_ACK && !timeout_hit) wait_cnt <= wait_cnt + 12'd1;
      else                                   wait_cnt <= '0;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      state                <= IDLE;
      pending              <= '0;
      last_grant           <= IW'(NUM_PORTS - 1);
      owner                <= '0;
      dram_addr_req_read   <= '0;
      dram_addr_req_write  <= '0;
      dram_addr_req_common <= '0;
      dram_lane_to_dram    <= '0;
      dram_entry_dirty     <= 1'b0;
      dram_req_read_pulse  <= 1'b0;
      port_ack_pulse       <= '0;
      port_lane_from_dram  <= '0;
    end else begin
      state               <= state_next;
      pending             <= (pending & ~clear_mask) | accept;
      dram_req_read_pulse <= 1'b0;
      port_ack_pulse      <= '0;
      // Operands are loaded only on a grant, so they hold through the controller's late sampling.
      if (state == IDLE && grant_found) begin
        owner                <= grant_idx;
        dram_addr_req_read   <= slot_read[grant_idx];
        dram_addr_req_write  <= slot_write[grant_idx];
        dram_addr_req_common <= slot_common[grant_idx];
        dram_entry_dirty     <= slot_dirty[grant_idx];
        dram_lane_to_dram    <= slot_lane[grant_idx];
        dram_req_read_pulse  <= 1'b1;
      end
      if (ack_take) begin
        port_lane_from_dram   <= dram_lane_from_dram;
        port_ack_pulse[owner] <= 1'b1;
        last_grant            <= owner;
      end
    end
  end

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Self-checking bench for dram_request_arbiter: vector table, corner-case sequences and a
// randomized run against a transaction-level round-robin model.
module tb_dram_request_arbiter;

  localparam int P = 2;

  logic             main_clk = 1'b0;
  logic             main_reset;
  logic [P-1:0]     port_req_pulse;
  logic [P*13-1:0]  port_addr_read_upper;
  logic [P*13-1:0]  port_addr_write_upper;
  logic [P*9-1:0]   port_addr_common;
  logic [P-1:0]     port_entry_dirty;
  logic [P*128-1:0] port_lane_to_dram;
  logic [P-1:0]     port_ack_pulse;
  logic [127:0]     port_lane_from_dram;
  logic [12:0]      dram_addr_req_read;
  logic [12:0]      dram_addr_req_write;
  logic [8:0]       dram_addr_req_common;
  logic [127:0]     dram_lane_to_dram;
  logic             dram_entry_dirty;
  logic             dram_req_read_pulse;
  logic [127:0]     dram_lane_from_dram;
  logic             dram_ack_read_pulse;
  logic             busy;
  logic             err_timeout;

  dram_request_arbiter #(.NUM_PORTS(P)) dut (
    .main_clk              (main_clk),
    .main_reset            (main_reset),
    .port_req_pulse        (port_req_pulse),
    .port_addr_read_upper  (port_addr_read_upper),
    .port_addr_write_upper (port_addr_write_upper),
    .port_addr_common      (port_addr_common),
    .port_entry_dirty      (port_entry_dirty),
    .port_lane_to_dram     (port_lane_to_dram),
    .port_ack_pulse        (port_ack_pulse),
    .port_lane_from_dram   (port_lane_from_dram),
    .dram_addr_req_read    (dram_addr_req_read),
    .dram_addr_req_write   (dram_addr_req_write),
    .dram_addr_req_common  (dram_addr_req_common),
    .dram_lane_to_dram     (dram_lane_to_dram),
    .dram_entry_dirty      (dram_entry_dirty),
    .dram_req_read_pulse   (dram_req_read_pulse),
    .dram_lane_from_dram   (dram_lane_from_dram),
    .dram_ack_read_pulse   (dram_ack_read_pulse),
    .busy                  (busy),
    .err_timeout           (err_timeout)
  );

  always #5 main_clk = ~main_clk;

  int errors = 0;
  int checks = 0;

  // Operand bundle layout: {read[12:0], write[12:0], common[8:0], dirty, lane[127:0]}
  typedef struct {
    int           port;
    logic [163:0] ops;
    logic [127:0] rlane;
    int           delay;
    logic [P-1:0] exp_ack;
  } vec_t;

  vec_t vt[4];

  logic [163:0] a0, a1, a2, a3, a4, h, alt, d1, d2, r0, r1, t0;
  logic [127:0] ln;
  bit           ok;
  int           n, reqs, acks, ack_due, extra, gap;
  bit           errseen;

  logic [P-1:0] m_pend, prev_pend, pulses, np, ack_exp;
  logic [163:0] m_slot [P];
  logic [163:0] rnd_in [P];
  logic [163:0] m_ops;
  logic [127:0] m_lane, ack_lane;
  bit           m_out, req_exp, real_ack;
  int           m_owner, m_last, ack_at, pick;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge main_clk);
    #1;
    port_req_pulse      = '0;
    dram_ack_read_pulse = 1'b0;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [163:0] mk_ops(input logic [12:0] rd, input logic [12:0] wr,
                                          input logic [8:0] cm, input logic d,
                                          input logic [127:0] lane);
    return {rd, wr, cm, d, lane};
  endfunction

  function automatic logic [163:0] rand_ops();
    return mk_ops(13'($urandom), 13'($urandom), 9'($urandom), 1'($urandom), rand128());
  endfunction

  function automatic logic [163:0] dut_ops();
    return {dram_addr_req_read, dram_addr_req_write, dram_addr_req_common,
            dram_entry_dirty, dram_lane_to_dram};
  endfunction

  function automatic int rr_pick(input logic [P-1:0] pend, input int last);
    logic [P-1:0] sh;
    for (int k = 1; k <= P; k++) begin
      sh = pend >> ((last + k) % P);
      if (sh[0]) return (last + k) % P;
    end
    return -1;
  endfunction

  task automatic set_port(input int i, input logic [163:0] ops);
    logic [P-1:0] m;
    m = P'(1) << i;
    port_addr_read_upper[i*13 +: 13]  = ops[163:151];
    port_addr_write_upper[i*13 +: 13] = ops[150:138];
    port_addr_common[i*9 +: 9]        = ops[137:129];
    port_entry_dirty                  = ops[128] ? (port_entry_dirty | m) : (port_entry_dirty & ~m);
    port_lane_to_dram[i*128 +: 128]   = ops[127:0];
    port_req_pulse                    = port_req_pulse | m;
  endtask

  task automatic ack_with(input logic [127:0] lane);
    dram_lane_from_dram = lane;
    dram_ack_read_pulse = 1'b1;
    tick();
  endtask

  task automatic wait_req(input int max, output bit found, output int cyc);
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < max) begin
      if (dram_req_read_pulse === 1'b1) found = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_req: no dram_req_read_pulse within %0d cycles", max);
    end
  endtask

  // Waits for the next controller request, checks its operands, acks it and checks the port ack.
  task automatic serve(input string name, input logic [163:0] exp_ops, input logic [P-1:0] exp_ack);
    bit           f;
    int           c;
    logic [127:0] lane;
    wait_req(20, f, c);
    check({name, "_ops"}, dut_ops(), exp_ops);
    tick();
    tick();
    lane = rand128();
    ack_with(lane);
    check({name, "_ack"}, port_ack_pulse, exp_ack);
    check({name, "_lane"}, port_lane_from_dram, lane);
  endtask

  task automatic do_reset();
    main_reset = 1'b1;
    tick();
    tick();
    main_reset = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ack"},  port_ack_pulse, '0);
    check({name, "_lane"}, port_lane_from_dram, '0);
    check({name, "_ops"},  dut_ops(), '0);
    check({name, "_req"},  dram_req_read_pulse, 1'b0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_err"},  err_timeout, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    main_reset            = 1'b1;
    port_req_pulse        = '0;
    port_addr_read_upper  = '0;
    port_addr_write_upper = '0;
    port_addr_common      = '0;
    port_entry_dirty      = '0;
    port_lane_to_dram     = '0;
    dram_lane_from_dram   = '0;
    dram_ack_read_pulse   = 1'b0;

    vt[0] = '{0, mk_ops(13'h0123, 13'h0000, 9'h045, 1'b0, '0), {16{8'hA5}}, 1, 2'b01};
    vt[1] = '{1, mk_ops(13'h1ABC, 13'h0777, 9'h1FF, 1'b1, {4{32'hDEADBEEF}}), {4{32'h0F0F0F0F}}, 3, 2'b10};
    vt[2] = '{0, mk_ops(13'h1FFF, 13'h1FFF, 9'h1FF, 1'b1, '1), '0, 2, 2'b01};
    vt[3] = '{1, mk_ops(13'h0000, 13'h0000, 9'h000, 1'b0, '0), '1, 5, 2'b10};

    do_reset();
    check_quiet("reset");

    // Single transactions: request at T+2, port ack and lane one cycle after the controller ack.
    for (int v = 0; v < 4; v++) begin
      set_port(vt[v].port, vt[v].ops);
      tick();
      check("vec_req_t1", dram_req_read_pulse, 1'b0);
      check("vec_busy_t1", busy, 1'b1);
      tick();
      check("vec_req_t2", dram_req_read_pulse, 1'b1);
      check("vec_ops_t2", dut_ops(), vt[v].ops);
      repeat (vt[v].delay) tick();
      check("vec_no_early_ack", port_ack_pulse, '0);
      ack_with(vt[v].rlane);
      check("vec_ack", port_ack_pulse, vt[v].exp_ack);
      check("vec_lane", port_lane_from_dram, vt[v].rlane);
      check("vec_ops_hold", dut_ops(), vt[v].ops);
      check("vec_busy_done", busy, 1'b0);
      tick();
      check("vec_ack_one_cycle", port_ack_pulse, '0);
      check("vec_lane_held", port_lane_from_dram, vt[v].rlane);
    end

    // Reset during WAIT_ACK, then a stray controller ack.
    r0 = mk_ops(13'h0DDD, 13'h0123, 9'h0F0, 1'b1, rand128());
    set_port(0, r0);
    tick();
    wait_req(10, ok, n);
    tick();
    tick();
    do_reset();
    check_quiet("mid_reset");
    ack_with('1);
    check("stray_ack", port_ack_pulse, '0);
    check("stray_lane", port_lane_from_dram, '0);
    check("stray_busy", busy, 1'b0);
    r1 = mk_ops(13'h0EEE, 13'h0321, 9'h00F, 1'b0, rand128());
    set_port(1, r1);
    tick();
    tick();
    check("post_reset_req", dram_req_read_pulse, 1'b1);
    check("post_reset_ops", dut_ops(), r1);
    tick();
    ln = rand128();
    ack_with(ln);
    check("post_reset_ack", port_ack_pulse, 2'b10);

    // Contention and round-robin order; last grant is port 1 here.
    a0 = mk_ops(13'h0A00, 13'h0001, 9'h001, 1'b0, rand128());
    a1 = mk_ops(13'h0A01, 13'h0002, 9'h002, 1'b1, rand128());
    a2 = mk_ops(13'h0A02, 13'h0003, 9'h003, 1'b0, rand128());
    a3 = mk_ops(13'h0A03, 13'h0004, 9'h004, 1'b1, rand128());
    a4 = mk_ops(13'h0A04, 13'h0005, 9'h005, 1'b0, rand128());
    set_port(0, a0);
    set_port(1, a1);
    tick();
    serve("rr_pair1_first", a0, 2'b01);
    set_port(0, a2);
    serve("rr_pair1_second", a1, 2'b10);
    serve("rr_reaccept", a2, 2'b01);
    set_port(0, a3);
    set_port(1, a4);
    tick();
    serve("rr_pair2_first", a4, 2'b10);
    serve("rr_pair2_second", a3, 2'b01);

    // Operand hold while the port changes its inputs after the pulse.
    h   = mk_ops(13'h0AAA, 13'h1555, 9'h1AB, 1'b1, {8{16'h1111}});
    alt = mk_ops(13'h1234, 13'h0567, 9'h089, 1'b0, {8{16'h2222}});
    set_port(1, h);
    tick();
    set_port(1, alt);
    port_req_pulse = '0;
    wait_req(10, ok, n);
    for (int k = 0; k < 3; k++) begin
      check("hold_ops", dut_ops(), h);
      tick();
    end
    ln = rand128();
    ack_with(ln);
    check("hold_ops_after_ack", dut_ops(), h);
    check("hold_ack", port_ack_pulse, 2'b10);

    // Duplicate pulse while pending is dropped.
    d1 = mk_ops(13'h0BBB, 13'h0111, 9'h011, 1'b1, rand128());
    d2 = mk_ops(13'h0CCC, 13'h0222, 9'h022, 1'b0, rand128());
    set_port(1, d1);
    tick();
    set_port(1, d2);
    reqs    = 0;
    acks    = 0;
    ack_due = -1;
    for (int c = 0; c < 30; c++) begin
      if (dram_req_read_pulse) begin
        reqs++;
        check("dup_ops", dut_ops(), d1);
        ack_due = c + 3;
      end
      if (port_ack_pulse[1]) acks++;
      if (c == ack_due) begin
        dram_lane_from_dram = rand128();
        dram_ack_read_pulse = 1'b1;
      end
      tick();
    end
    check("dup_req_count", reqs, 1);
    check("dup_ack_count", acks, 1);

    // Withheld controller ack.
    t0 = rand_ops();
    set_port(0, t0);
    tick();
    wait_req(10, ok, n);
`ifdef DRAM_ARB_TIMEOUT_EN
    tick();
    gap = 1;
    ok  = 1'b0;
    while (!ok && gap < 4300) begin
      if (dram_req_read_pulse) ok = 1'b1;
      else begin
        tick();
        gap++;
      end
    end
    checks++;
    if (!ok || gap < 4095 || gap > 4098) begin
      errors++;
      $display("FAIL timeout_reissue: gap %0d cycles, required about 4097", gap);
    end
    check("timeout_err", err_timeout, 1'b1);
    check("timeout_reissue_ops", dut_ops(), t0);
    tick();
    ln = rand128();
    ack_with(ln);
    check("timeout_late_ack", port_ack_pulse, 2'b01);
    check("timeout_err_sticky", err_timeout, 1'b1);
`else
    extra   = 0;
    errseen = 1'b0;
    repeat (4200) begin
      tick();
      if (dram_req_read_pulse) extra++;
      if (err_timeout) errseen = 1'b1;
    end
    check("no_timeout_reissue", extra, 0);
    check("no_timeout_err", errseen, 1'b0);
    ln = rand128();
    ack_with(ln);
    check("no_timeout_late_ack", port_ack_pulse, 2'b01);
`endif

    // Randomized traffic against a transaction-level round-robin model.
    do_reset();
    check("rnd_reset_err", err_timeout, 1'b0);
    m_pend    = '0;
    prev_pend = '0;
    m_ops     = '0;
    m_lane    = '0;
    m_out     = 1'b0;
    req_exp   = 1'b0;
    ack_exp   = '0;
    m_last    = P - 1;
    m_owner   = 0;
    ack_at    = -1;
    for (int c = 0; c < 2300; c++) begin
      if (c >= 2000 && m_pend == '0 && !m_out) break;
      check("rnd_req", dram_req_read_pulse, req_exp);
      check("rnd_ack", port_ack_pulse, ack_exp);
      check("rnd_lane", port_lane_from_dram, m_lane);
      check("rnd_busy", busy, |m_pend);
      if (dram_req_read_pulse) begin
        pick = rr_pick(prev_pend, m_last);
        if (pick < 0) pick = 0;
        m_owner = pick;
        m_ops   = m_slot[pick];
        m_out   = 1'b1;
        ack_at  = c + int'($urandom_range(1, 6));
      end
      check("rnd_ops", dut_ops(), m_ops);

      pulses = '0;
      if (c < 2000) begin
        for (int i = 0; i < P; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            rnd_in[i] = rand_ops();
            set_port(i, rnd_in[i]);
            pulses = pulses | (P'(1) << i);
          end
        end
      end
      real_ack = m_out && (c == ack_at);
      if (real_ack || (!m_out && $urandom_range(0, 7) == 0)) begin
        ack_lane = rand128();
        ack_with_drive: begin
          dram_lane_from_dram = ack_lane;
          dram_ack_read_pulse = 1'b1;
        end
      end

      ack_exp   = '0;
      prev_pend = m_pend;
      req_exp   = !m_out && (m_pend != '0);
      np        = m_pend;
      if (real_ack) np = np & ~(P'(1) << m_owner);
      for (int i = 0; i < P; i++) begin
        if (((pulses >> i) & P'(1)) != '0 && ((m_pend >> i) & P'(1)) == '0) begin
          m_slot[i] = rnd_in[i];
          np        = np | (P'(1) << i);
        end
      end
      m_pend = np;
      if (real_ack) begin
        ack_exp = P'(1) << m_owner;
        m_lane  = ack_lane;
        m_last  = m_owner;
        m_out   = 1'b0;
      end
      tick();
    end
    check("rnd_drained", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
